// File: rtl/poly_oscillator.sv
// rtl/poly_oscillator.sv - time-multiplexed polyphonic sine oscillator with note-command port
// Optional macro POLY_OSC_PHASE_RESET_EN: every note-on restarts the voice phase at 0.
module poly_oscillator #(
  parameter int VOICES    = 4,
  parameter int KEY_W     = 7,
  parameter int OSC_DEPTH = 12,
  parameter int ACC_W     = 24,
  parameter int LUT_W     = 8,
  parameter int CLK_HZ    = 50_000_000,
  localparam int VW       = $clog2(VOICES),
  localparam int SUM_W    = OSC_DEPTH + VW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [VW-1:0]     cmd_voice,
  input  logic [KEY_W-1:0]  cmd_key,
  output logic [SUM_W-1:0]  v,
  output logic              v_valid,
  output logic [VOICES-1:0] active
);

  localparam int LUT_N = 2 ** LUT_W;
  localparam int MID   = 2 ** (OSC_DEPTH - 1);
  localparam logic [SUM_W-1:0] SILENCE = SUM_W'(VOICES * MID);
  localparam logic [VW-1:0]    LAST    = VW'(VOICES - 1);
`ifdef POLY_OSC_PHASE_RESET_EN
  localparam bit PHASE_RST = 1'b1;
`else
  localparam bit PHASE_RST = 1'b0;
`endif

  // Quarter-wave table holds the upper half of the waveform: MID .. 2^OSC_DEPTH-1.
  function automatic int lut_val(int i);
    real ang;
    ang = 3.14159265358979 / 2.0 * real'(i) / real'(LUT_N);
    return MID + $rtoi(real'(MID - 1) * $sin(ang) + 0.5);
  endfunction

  // Increments of the top octave (keys 85..96); lower octaves are right shifts.
  function automatic int base_val(int s);
    real f;
    f = 440.0 * (2.0 ** (real'(36 + s) / 12.0));
    return $rtoi(f * (2.0 ** ACC_W) * real'(VOICES) / real'(CLK_HZ) + 0.5);
  endfunction

  logic [OSC_DEPTH-1:0] sine_rom [LUT_N];
  logic [ACC_W-1:0]     base_tab [12];

  for (genvar i = 0; i < LUT_N; i++) begin : g_rom
    localparam int LV = lut_val(i);
    assign sine_rom[i] = OSC_DEPTH'(LV);
  end

  for (genvar s = 0; s < 12; s++) begin : g_base
    localparam int BV = base_val(s);
    assign base_tab[s] = ACC_W'(BV);
  end

  logic                 key_on;
  logic [KEY_W-1:0]     key_m1;
  logic [3:0]           semi;
  logic [2:0]           oct;
  logic [ACC_W-1:0]     key_inc;

  always_comb begin
    key_m1  = cmd_key - KEY_W'(1);
    key_on  = (cmd_key != '0) && (cmd_key <= KEY_W'(88));
    semi    = 4'(key_m1 % KEY_W'(12));
    oct     = 3'(key_m1 / KEY_W'(12));
    key_inc = '0;
    if (key_on) key_inc = base_tab[semi] >> (3'd7 - oct);
  end

  logic             pend_vld;
  logic [VW-1:0]    pend_voice;
  logic [ACC_W-1:0] pend_inc;
  logic             pend_zero;

  assign cmd_ready = !pend_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld   <= 1'b0;
      pend_voice <= '0;
      pend_inc   <= '0;
      pend_zero  <= 1'b0;
      active     <= '0;
    end else begin
      pend_vld <= cmd_valid && cmd_ready;
      if (cmd_valid && cmd_ready) begin
        pend_voice        <= cmd_voice;
        pend_inc          <= key_inc;
        pend_zero         <= !key_on || PHASE_RST;
        active[cmd_voice] <= key_on;
      end
    end
  end

  logic [VW-1:0]    slot;
  logic [ACC_W-1:0] acc [VOICES];
  logic [ACC_W-1:0] inc [VOICES];

  // S0; a pending zero-phase write overrides the same-cycle accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
      for (int i = 0; i < VOICES; i++) begin
        acc[i] <= '0;
        inc[i] <= '0;
      end
    end else begin
      slot      <= slot + VW'(1);
      acc[slot] <= acc[slot] + inc[slot];
      if (pend_vld) begin
        inc[pend_voice] <= pend_inc;
        if (pend_zero) acc[pend_voice] <= '0;
      end
    end
  end

  logic [VW-1:0]        s1_slot, s2_slot, s3_slot;
  logic [1:0]           quad;
  logic [LUT_W-1:0]     addr;
  logic [OSC_DEPTH-1:0] s2_lut, s3_sample;
  logic                 s2_neg;
  logic [SUM_W-1:0]     sum;

  assign quad = acc[s1_slot][ACC_W-1 -: 2];
  assign addr = acc[s1_slot][ACC_W-3 -: LUT_W] ^ {LUT_W{quad[0]}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_slot   <= '0;
      s2_slot   <= '0;
      s3_slot   <= '0;
      s2_lut    <= '0;
      s2_neg    <= 1'b0;
      s3_sample <= '0;
      sum       <= '0;
      v         <= SILENCE;
      v_valid   <= 1'b0;
    end else begin
      s1_slot   <= slot;
      s2_slot   <= s1_slot;
      s2_lut    <= sine_rom[addr];
      s2_neg    <= quad[1];
      s3_slot   <= s2_slot;
      s3_sample <= s2_neg ? ~s2_lut : s2_lut;
      sum       <= (s3_slot == '0) ? SUM_W'(s3_sample) : sum + SUM_W'(s3_sample);
      v_valid   <= (s3_slot == LAST);
      if (s3_slot == LAST) v <= sum + SUM_W'(s3_sample);
    end
  end

endmodule

// File: tb/tb_poly_oscillator.sv
// tb/tb_poly_oscillator.sv - self-checking bench for poly_oscillator with frame-level reference model
module tb_poly_oscillator;
  localparam int VOICES = 4, KEY_W = 7, OSC_DEPTH = 12, ACC_W = 24, LUT_W = 8;
  localparam int CLK_HZ = 50_000_000, VW = 2, SUM_W = 14;
`ifdef POLY_OSC_PHASE_RESET_EN
  localparam bit PHASE_RST = 1'b1;
`else
  localparam bit PHASE_RST = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0;
  logic cmd_ready, v_valid;
  logic [VW-1:0] cmd_voice = '0;
  logic [KEY_W-1:0] cmd_key = '0;
  logic [SUM_W-1:0] v;
  logic [VOICES-1:0] active;

  int n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  poly_oscillator dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_voice(cmd_voice), .cmd_key(cmd_key), .v(v), .v_valid(v_valid), .active(active)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: ideal note frequency quantised to an accumulator step.
  function automatic int model_inc(input int key);
    int s, o;
    real f;
    if (key < 1 || key > 88) return 0;
    s = (key - 1) % 12;
    o = (key - 1) / 12;
    f = 440.0 * (2.0 ** ((real'(85 + s) - 49.0) / 12.0));
    return $rtoi(f * 16777216.0 * VOICES / CLK_HZ + 0.5) >> (7 - o);
  endfunction

  function automatic int model_sample(input int unsigned phase);
    int p, q, a, m, amp;
    p = int'(phase >> (ACC_W - 2 - LUT_W));
    q = p / 256;
    a = p % 256;
    m = (q % 2 == 1) ? 255 - a : a;
    amp = $rtoi(2047.0 * $sin(3.14159265358979 / 2.0 * m / 256.0) + 0.5);
    return (q < 2) ? 2048 + amp : 2047 - amp;
  endfunction

  typedef struct { int due; int val; } exp_t;
  exp_t expq[$];
  int unsigned m_acc [VOICES];
  int unsigned m_inc [VOICES];
  bit m_pend, m_pzero, chk_act, take, on;
  int m_pv, edges, fsum, s;
  int unsigned m_pinc;
  logic [VOICES-1:0] m_active;

  always @(negedge clk) begin
    if (!rst_n) begin
      edges = 0; fsum = 0; m_pend = 0; chk_act = 0; m_active = '0;
      expq.delete();
      for (int i = 0; i < VOICES; i++) begin m_acc[i] = 0; m_inc[i] = 0; end
    end else begin
      if (expq.size() != 0 && expq[0].due == edges) begin
        check("strobe", v_valid, 1);
        check("frame_v", v, expq[0].val);
        void'(expq.pop_front());
      end else if (v_valid) check("strobe_extra", v_valid, 0);
      if (chk_act) check("active", active, m_active);
      chk_act = 0;
      if (cmd_valid) check("cmd_ready", cmd_ready, !m_pend);
      s = edges % VOICES;
      take = cmd_valid && !m_pend;
      m_acc[s] = (m_acc[s] + m_inc[s]) & 32'hFF_FFFF;
      if (m_pend) begin
        m_inc[m_pv] = m_pinc;
        if (m_pzero) m_acc[m_pv] = 0;
        m_pend = 0;
      end
      if (take) begin
        on = (cmd_key >= 1 && cmd_key <= 88);
        m_pend = 1; m_pv = cmd_voice; m_pinc = model_inc(cmd_key);
        m_pzero = !on || PHASE_RST;
        m_active[cmd_voice] = on;
        chk_act = 1;
      end
      fsum += model_sample(m_acc[s]);
      edges++;
      if (s == VOICES - 1) begin
        expq.push_back('{edges + 3, fsum});
        fsum = 0;
      end
    end
  end

  task automatic send_cmd(input int voice, input int key);
    int n;
    n = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_voice = VW'(voice); cmd_key = KEY_W'(key);
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 10);
    if (!cmd_ready) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic edges_to_strobe(input string name, input int exp);
    int n;
    n = 0;
    do begin @(posedge clk); n++; @(negedge clk); end while (!v_valid && n < 50);
    check(name, n, exp);
  endtask

  typedef struct { int voice; int key; logic [3:0] act; } vec_t;
  vec_t tbl [12];
  int bb [6][2];
  int idx, cyc, fr, vprev, vmax, vmin, first, second;
  bit rdy;

  initial begin
    tbl[0]  = '{0, 49,  4'b0001};  tbl[1]  = '{1, 60,  4'b0011};
    tbl[2]  = '{2, 76,  4'b0111};  tbl[3]  = '{3, 88,  4'b1111};
    tbl[4]  = '{1, 0,   4'b1101};  tbl[5]  = '{2, 100, 4'b1001};
    tbl[6]  = '{3, 89,  4'b0001};  tbl[7]  = '{2, 1,   4'b0101};
    tbl[8]  = '{0, 127, 4'b0100};  tbl[9]  = '{3, 40,  4'b1100};
    tbl[10] = '{2, 0,   4'b1000};  tbl[11] = '{3, 0,   4'b0000};
    bb[0] = '{0, 88}; bb[1] = '{1, 88}; bb[2] = '{0, 0};
    bb[3] = '{1, 100}; bb[4] = '{2, 50}; bb[5] = '{3, 0};

    // Reset values and first-strobe latency
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_v", v, 8192);
    check("rst_v_valid", v_valid, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_active", active, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    edges_to_strobe("first_strobe_latency", VOICES + 3);
    edges_to_strobe("strobe_period", VOICES);
    repeat (40) @(posedge clk);

    // Table-driven command vectors
    for (int i = 0; i < 12; i++) begin
      send_cmd(tbl[i].voice, tbl[i].key);
      @(negedge clk);
      check("ready_low_after_accept", cmd_ready, 0);
      check("tbl_active", active, tbl[i].act);
      @(negedge clk);
      check("ready_high_again", cmd_ready, 1);
      repeat (30) @(posedge clk);
    end

    // Back-to-back commands with cmd_valid held high
    @(posedge clk); #1;
    idx = 0; cmd_valid = 1'b1; cmd_voice = VW'(bb[0][0]); cmd_key = KEY_W'(bb[0][1]);
    for (cyc = 0; cyc < 40 && idx < 6; cyc++) begin
      @(negedge clk); rdy = cmd_ready;
      @(posedge clk); #1;
      if (rdy) begin
        idx++;
        if (idx < 6) begin cmd_voice = VW'(bb[idx][0]); cmd_key = KEY_W'(bb[idx][1]); end
        else cmd_valid = 1'b0;
      end
    end
    check("b2b_accepted", idx, 6);
    check("b2b_cycles", cyc, 11);
    @(negedge clk);
    check("b2b_active", active, 4'b0100);
    repeat (40) @(posedge clk);

    // Key sweep on voice 2
    for (int k = 76; k >= 25; k--) begin
      send_cmd(2, k);
      repeat (64 * VOICES) @(posedge clk);
    end

    // Randomised command traffic
    for (int i = 0; i < 150; i++) begin
      send_cmd($urandom_range(0, VOICES - 1), $urandom_range(0, 127));
      repeat ($urandom_range(0, 16)) @(posedge clk);
    end

    // Mid-frame reset with three active voices
    send_cmd(0, 60); send_cmd(1, 64); send_cmd(2, 67); send_cmd(3, 0);
    repeat (50) @(posedge clk);
    @(negedge clk);
    check("pre_reset_active", active, 4'b0111);
    while (edges % VOICES != 2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("midrst_v", v, 8192);
    check("midrst_v_valid", v_valid, 0);
    check("midrst_active", active, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    edges_to_strobe("midrst_first_strobe", 7);

    // All voices key 88: peak, trough and measured frequency
    for (int i = 0; i < VOICES; i++) send_cmd(i, 88);
    @(negedge clk);
    check("all_on_active", active, 4'b1111);
    fr = 0; vprev = 8192; vmax = 0; vmin = 1 << 20; first = -1; second = -1;
    for (int c = 0; c < 6500 * VOICES && second < 0; c++) begin
      @(negedge clk);
      if (v_valid) begin
        fr++;
        if (v > vmax) vmax = v;
        if (v < vmin) vmin = v;
        if (vprev < 8192 && v >= 8192) begin
          if (first < 0) first = fr; else second = fr;
        end
        vprev = v;
      end
    end
    check("peak", vmax, 16380);
    check("trough", vmin, 0);
    $display("key 88 period %0d frames", second - first);
    check("freq_k88_within_0p5pct", (second > 0) && (second - first >= 2971) && (second - first <= 3001), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #990_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end
endmodule
